dmem_responder: RTL and testbench

- Memory-side responder for the core's M-stage data-memory interface.
- Accepts the core's load and store requests: address, write data, width code, and read/write strobes.
- Converts each request into a single-outstanding request/response transaction on a backing data bus. Generates byte enables and replicated write lanes.
- Holds the core's M stage via a stall output until the transaction completes, then returns the full 32-bit read word. Load sign/zero reduction stays in the core.

---
 rtl/dmem_responder.sv | 183 ++++++++++++++++++
 tb/tb_dmem_responder.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// dmem_responder : M-stage data-memory request -> single-outstanding bus txn
// Revision       : 1.0
// ============================================================================
module dmem_responder #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] RESET_RDATA    = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic        mem_read_m_i,
  input  logic        mem_write_m_i,
  input  logic [31:0] addr_m_i,
  input  logic [31:0] write_data_m_i,
  input  logic [2:0]  width_src_m_i,
  input  logic        hold_i,
  output logic [31:0] read_data_m_o,
  output logic        stall_mem_o,
  output logic        misalign_o,
  output logic        timeout_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [29:0] bus_addr_o,
  output logic [3:0]  bus_be_o,
  output logic [31:0] bus_wdata_o,
  input  logic        bus_ready_i,
  input  logic        bus_rvalid_i,
  input  logic [31:0] bus_rdata_i
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [CNT_W-1:0]  count_q;
  logic              we_q;
  logic [29:0]       addr_q;
  logic [3:0]        be_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rdata_q;

  logic              access;
  logic              is_byte;
  logic              is_half;
  logic              misaligned;
  logic [3:0]        be_next;
  logic [31:0]       wdata_next;
  logic              count_last;

  logic              stall;
  logic              misalign;
  logic              timeout;
  logic              req;
  logic              latch;
  logic              capture;

  // Width bit 2 carries the load sign selection, which the core applies itself.
  logic              unused_width_bit;
  assign unused_width_bit = width_src_m_i[2];

  assign access     = mem_read_m_i | mem_write_m_i;
  assign is_byte    = (width_src_m_i[1:0] == 2'b00);
  assign is_half    = (width_src_m_i[1:0] == 2'b01);
  assign misaligned = is_half ? addr_m_i[0]
                    : (!is_byte && (addr_m_i[1:0] != 2'b00));
  assign count_last = (count_q == CNT_LAST);

  always_comb begin
    be_next    = 4'b1111;
    wdata_next = write_data_m_i;
    if (is_byte) begin
      be_next    = 4'b0001 << addr_m_i[1:0];
      wdata_next = {4{write_data_m_i[7:0]}};
    end else if (is_half) begin
      be_next    = 4'b0011 << {addr_m_i[1], 1'b0};
      wdata_next = {2{write_data_m_i[15:0]}};
    end
  end

  always_comb begin
    state_d  = state_q;
    stall    = 1'b0;
    misalign = 1'b0;
    timeout  = 1'b0;
    req      = 1'b0;
    latch    = 1'b0;
    capture  = 1'b0;
    case (state_q)
      IDLE: begin
        if (access) begin
          if (misaligned) begin
            misalign = 1'b1;
          end else begin
            stall   = 1'b1;
            latch   = 1'b1;
            state_d = REQ;
          end
        end
      end
      REQ: begin
        stall = 1'b1;
        // The request is withdrawn in the expiry cycle so a late accept can't slip through.
        if (count_last) begin
          timeout = 1'b1;
          state_d = DONE;
        end else begin
          req = 1'b1;
          if (bus_ready_i) begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        stall = 1'b1;
        if (bus_rvalid_i) begin
          capture = 1'b1;
          state_d = DONE;
        end else if (count_last) begin
          timeout = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (!hold_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= IDLE;
      count_q <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      rdata_q <= RESET_RDATA;
    end else begin
      state_q <= state_d;
      if ((state_q == REQ || state_q == WAIT) && (state_d == REQ || state_d == WAIT)) begin
        count_q <= count_q + 1'b1;
      end else begin
        count_q <= '0;
      end
      if (latch) begin
        we_q    <= mem_write_m_i;
        addr_q  <= addr_m_i[31:2];
        be_q    <= be_next;
        wdata_q <= wdata_next;
      end
      if (capture && !we_q) begin
        rdata_q <= bus_rdata_i;
      end else if (misalign || timeout) begin
        rdata_q <= RESET_RDATA;
      end
    end
  end

  // Combinational outputs are gated so every output reads 0 while reset is held.
  assign stall_mem_o   = stall & reset_n_i;
  assign misalign_o    = misalign & reset_n_i;
  assign timeout_o     = timeout & reset_n_i;
  assign bus_req_o     = req & reset_n_i;
  assign bus_we_o      = we_q;
  assign bus_addr_o    = addr_q;
  assign bus_be_o      = be_q;
  assign bus_wdata_o   = wdata_q;
  assign read_data_m_o = (misalign_o | timeout_o) ? RESET_RDATA : rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// tb_dmem_responder : directed self-checking bench for dmem_responder
// Revision          : 1.0
// ============================================================================
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [2:0]  width = '0;
  logic        hold = 1'b0;
  logic        bus_ready = 1'b0;
  logic        bus_rvalid = 1'b0;
  logic [31:0] bus_rdata = '0;
  logic        to_ready = 1'b0;
  logic        to_rvalid = 1'b0;

  logic [31:0] read_data, t_read_data;
  logic        stall, misalign, timeout, bus_req, bus_we;
  logic        t_stall, t_misalign, t_timeout, t_bus_req, t_bus_we;
  logic [29:0] bus_addr, t_bus_addr;
  logic [3:0]  bus_be, t_bus_be;
  logic [31:0] bus_wdata, t_bus_wdata;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dmem_responder dut (
    .clk_i(clk), .reset_n_i(reset_n),
    .mem_read_m_i(mem_read), .mem_write_m_i(mem_write),
    .addr_m_i(addr), .write_data_m_i(wdata), .width_src_m_i(width),
    .hold_i(hold), .read_data_m_o(read_data), .stall_mem_o(stall),
    .misalign_o(misalign), .timeout_o(timeout),
    .bus_req_o(bus_req), .bus_we_o(bus_we), .bus_addr_o(bus_addr),
    .bus_be_o(bus_be), .bus_wdata_o(bus_wdata),
    .bus_ready_i(bus_ready), .bus_rvalid_i(bus_rvalid), .bus_rdata_i(bus_rdata)
  );

  dmem_responder #(.TIMEOUT_CYCLES(4)) dut_to (
    .clk_i(clk), .reset_n_i(reset_n),
    .mem_read_m_i(mem_read), .mem_write_m_i(mem_write),
    .addr_m_i(addr), .write_data_m_i(wdata), .width_src_m_i(width),
    .hold_i(hold), .read_data_m_o(t_read_data), .stall_mem_o(t_stall),
    .misalign_o(t_misalign), .timeout_o(t_timeout),
    .bus_req_o(t_bus_req), .bus_we_o(t_bus_we), .bus_addr_o(t_bus_addr),
    .bus_be_o(t_bus_be), .bus_wdata_o(t_bus_wdata),
    .bus_ready_i(to_ready), .bus_rvalid_i(to_rvalid), .bus_rdata_i(bus_rdata)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1 reset_n = 1'b0;
    mem_read = 1'b1; addr = 32'h100; width = 3'b010;
    step(); step();
    checks++;
    if ({stall, misalign, timeout, bus_req, bus_we, bus_addr, bus_be, bus_wdata} !== 71'd0) begin
      failures++;
      $display("FAIL reset_outputs: got %h want 0", {stall, misalign, timeout, bus_req, bus_we, bus_addr, bus_be, bus_wdata});
    end
    checks++;
    if (read_data !== 32'h0) begin failures++; $display("FAIL reset_rdata: got %h want 00000000", read_data); end
    mem_read = 1'b0; reset_n = 1'b1;
    step();
    checks++;
    if ({stall, bus_req} !== 2'b00) begin failures++; $display("FAIL reset_idle: got %b want 00", {stall, bus_req}); end
  endtask

  task automatic test_word_load();
    step(); mem_read = 1'b1; addr = 32'h100; width = 3'b010; #1;
    checks++;
    if ({stall, bus_req} !== 2'b10) begin failures++; $display("FAIL load_c0: got %b want 10", {stall, bus_req}); end
    step(); bus_ready = 1'b1; #1;
    checks++;
    if ({stall, bus_req, bus_we, bus_addr, bus_be} !== {1'b1, 1'b1, 1'b0, 30'h40, 4'hF}) begin
      failures++;
      $display("FAIL load_req: got %h want %h", {stall, bus_req, bus_we, bus_addr, bus_be}, {1'b1, 1'b1, 1'b0, 30'h40, 4'hF});
    end
    step(); bus_ready = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'hCAFEBABE; #1;
    checks++;
    if ({stall, bus_req} !== 2'b10) begin failures++; $display("FAIL load_wait: got %b want 10", {stall, bus_req}); end
    step(); bus_rvalid = 1'b0; mem_read = 1'b0; #1;
    checks++;
    if ({stall, read_data} !== {1'b0, 32'hCAFEBABE}) begin
      failures++; $display("FAIL load_done: got stall=%b data=%h want stall=0 data=cafebabe", stall, read_data);
    end
    step();
    checks++;
    if ({stall, bus_req} !== 2'b00) begin failures++; $display("FAIL load_idle: got %b want 00", {stall, bus_req}); end
  endtask

  task automatic test_byte_store();
    step(); mem_write = 1'b1; mem_read = 1'b1; addr = 32'h203; wdata = 32'h12345678; width = 3'b000; #1;
    checks++;
    if (stall !== 1'b1) begin failures++; $display("FAIL bstore_c0: got stall=%b want 1", stall); end
    step(); bus_ready = 1'b1; #1;
    checks++;
    if ({bus_req, bus_we, bus_addr, bus_be, bus_wdata} !== {1'b1, 1'b1, 30'h80, 4'h8, 32'h78787878}) begin
      failures++;
      $display("FAIL bstore_req: got %h want %h", {bus_req, bus_we, bus_addr, bus_be, bus_wdata}, {1'b1, 1'b1, 30'h80, 4'h8, 32'h78787878});
    end
    step(); bus_ready = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'h99999999; #1;
    checks++;
    if ({stall, bus_req} !== 2'b10) begin failures++; $display("FAIL bstore_wait: got %b want 10", {stall, bus_req}); end
    step(); bus_rvalid = 1'b0; mem_write = 1'b0; mem_read = 1'b0; #1;
    checks++;
    if ({stall, read_data} !== {1'b0, 32'hCAFEBABE}) begin
      failures++; $display("FAIL bstore_done: got stall=%b data=%h want stall=0 data=cafebabe", stall, read_data);
    end
    step();
  endtask

  task automatic test_half_and_misalign();
    step(); mem_write = 1'b1; addr = 32'h202; wdata = 32'h0000ABCD; width = 3'b101; #1;
    step(); bus_ready = 1'b1; #1;
    checks++;
    if ({bus_req, bus_we, bus_addr, bus_be, bus_wdata} !== {1'b1, 1'b1, 30'h80, 4'hC, 32'hABCDABCD}) begin
      failures++;
      $display("FAIL hstore_req: got %h want %h", {bus_req, bus_we, bus_addr, bus_be, bus_wdata}, {1'b1, 1'b1, 30'h80, 4'hC, 32'hABCDABCD});
    end
    step(); bus_ready = 1'b0; bus_rvalid = 1'b1; #1;
    step(); bus_rvalid = 1'b0; mem_write = 1'b0; #1;
    checks++;
    if (stall !== 1'b0) begin failures++; $display("FAIL hstore_done: got stall=%b want 0", stall); end
    step(); mem_read = 1'b1; addr = 32'h201; width = 3'b001; #1;
    checks++;
    if ({misalign, stall, bus_req, read_data} !== {3'b100, 32'h0}) begin
      failures++; $display("FAIL misalign_pulse: got %h want %h", {misalign, stall, bus_req, read_data}, {3'b100, 32'h0});
    end
    step(); mem_read = 1'b0; #1;
    checks++;
    if ({misalign, stall, bus_req, read_data} !== {3'b000, 32'h0}) begin
      failures++; $display("FAIL misalign_after: got %h want %h", {misalign, stall, bus_req, read_data}, {3'b000, 32'h0});
    end
  endtask

  task automatic test_ready_wait();
    step(); mem_read = 1'b1; addr = 32'h10; width = 3'b010; #1;
    for (int i = 0; i < 6; i++) begin
      step();
      if (i == 5) bus_ready = 1'b1;
      #1;
      checks++;
      if ({bus_req, bus_we, bus_addr, bus_be, stall} !== {1'b1, 1'b0, 30'h4, 4'hF, 1'b1}) begin
        failures++;
        $display("FAIL ready_hold_%0d: got %h want %h", i, {bus_req, bus_we, bus_addr, bus_be, stall}, {1'b1, 1'b0, 30'h4, 4'hF, 1'b1});
      end
    end
    step(); bus_ready = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'h11223344; #1;
    checks++;
    if (bus_req !== 1'b0) begin failures++; $display("FAIL ready_wait_req: got %b want 0", bus_req); end
    step(); bus_rvalid = 1'b0; mem_read = 1'b0; #1;
    checks++;
    if ({stall, read_data} !== {1'b0, 32'h11223344}) begin
      failures++; $display("FAIL ready_done: got stall=%b data=%h want stall=0 data=11223344", stall, read_data);
    end
    step();
  endtask

  task automatic test_hold_and_reset();
    step(); mem_read = 1'b1; addr = 32'h20; width = 3'b010; #1;
    step(); bus_ready = 1'b1; #1;
    step(); bus_ready = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'h55AA55AA; #1;
    step(); bus_rvalid = 1'b0; hold = 1'b1; #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({stall, bus_req, read_data} !== {2'b00, 32'h55AA55AA}) begin
        failures++; $display("FAIL hold_done_%0d: got %h want %h", i, {stall, bus_req, read_data}, {2'b00, 32'h55AA55AA});
      end
      step();
      if (i == 1) hold = 1'b0;
      #1;
    end
    addr = 32'h24; #1;
    checks++;
    if ({stall, bus_req} !== 2'b10) begin failures++; $display("FAIL hold_release_idle: got %b want 10", {stall, bus_req}); end
    step(); bus_ready = 1'b1; #1;
    checks++;
    if ({bus_req, bus_addr} !== {1'b1, 30'h9}) begin
      failures++; $display("FAIL hold_next_req: got %h want %h", {bus_req, bus_addr}, {1'b1, 30'h9});
    end
    step(); bus_ready = 1'b0; #1;
    checks++;
    if ({stall, bus_req} !== 2'b10) begin failures++; $display("FAIL rst_wait: got %b want 10", {stall, bus_req}); end
    reset_n = 1'b0; mem_read = 1'b0; #1;
    checks++;
    if ({stall, bus_req, bus_addr} !== {2'b00, 30'h0}) begin
      failures++; $display("FAIL rst_immediate: got %h want 0", {stall, bus_req, bus_addr});
    end
    step(); reset_n = 1'b1; bus_rvalid = 1'b1; bus_rdata = 32'hDEADBEEF; #1;
    step(); bus_rvalid = 1'b0; #1;
    checks++;
    if ({stall, bus_req, read_data} !== {2'b00, 32'h0}) begin
      failures++; $display("FAIL rst_resp_ignored: got %h want 0", {stall, bus_req, read_data});
    end
  endtask

  task automatic test_timeout();
    step(); mem_read = 1'b1; addr = 32'h40; width = 3'b010; #1;
    checks++;
    if (t_stall !== 1'b1) begin failures++; $display("FAIL to_c0: got stall=%b want 1", t_stall); end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({t_bus_req, t_timeout, t_stall} !== 3'b101) begin
        failures++; $display("FAIL to_req_%0d: got %b want 101", i, {t_bus_req, t_timeout, t_stall});
      end
    end
    step();
    checks++;
    if ({t_bus_req, t_timeout, t_stall, t_read_data} !== {3'b011, 32'h0}) begin
      failures++; $display("FAIL to_pulse: got %h want %h", {t_bus_req, t_timeout, t_stall, t_read_data}, {3'b011, 32'h0});
    end
    step(); mem_read = 1'b0; #1;
    checks++;
    if ({t_bus_req, t_timeout, t_stall, t_read_data} !== {3'b000, 32'h0}) begin
      failures++; $display("FAIL to_done: got %h want %h", {t_bus_req, t_timeout, t_stall, t_read_data}, {3'b000, 32'h0});
    end
  endtask

  initial begin
    test_reset();
    test_word_load();
    test_byte_store();
    test_half_and_misalign();
    test_ready_wait();
    test_hold_and_reset();
    test_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
